// File: rtl/rv32i_mem_pkg.sv
// Shared definitions for the RV32I data-memory path: funct3 size codes,
// responder FSM states and the captured request record.
package rv32i_mem_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] STRB_B  = 3'b000;
  localparam logic [2:0] STRB_H  = 3'b001;
  localparam logic [2:0] STRB_W  = 3'b010;
  localparam logic [2:0] STRB_BU = 3'b100;
  localparam logic [2:0] STRB_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic              write;
    logic [2:0]        strobe;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for byte/half/word accesses: byte enables,
// store-data replication, load extraction/extension and alignment errors.
module dmem_lane_align
  import rv32i_mem_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        strobe,
  input  logic              write,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [3:0]        byte_en,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              align_err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rword[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rword[31:16] : rword[15:0];
    byte_en   = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    align_err = 1'b0;
    case (strobe)
      STRB_B: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      end
      STRB_BU: begin
        rdata_ext = {24'b0, byte_sel};
        align_err = write;
      end
      STRB_H: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{half_sel[15]}}, half_sel};
        align_err = addr_lo[0];
      end
      STRB_HU: begin
        rdata_ext = {16'b0, half_sel};
        align_err = addr_lo[0] | write;
      end
      STRB_W: begin
        byte_en   = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rword;
        align_err = |addr_lo;
      end
      default: align_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request capture, programmable wait
// states, one-cycle response pulse, byte-masked storage array.
module dmem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [DATA_W-1:0] ReqAddr,
  input  logic              ReqWrite,
  input  logic [2:0]        ReqStrobe,
  input  logic [DATA_W-1:0] ReqWData,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspRData,
  output logic              RspError
);

  state_e   state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  mem_req_t req_q, req_d;

  logic [DATA_W-1:0] mem_q [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [DATA_W-1:0]     rword;
  logic [DATA_W-1:0]     addr_hi;
  logic [3:0]            byte_en;
  logic [DATA_W-1:0]     wdata_rep;
  logic [DATA_W-1:0]     rdata_ext;
  logic                  align_err;
  logic                  acc_err;
  logic                  mem_we;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (ReqValid) begin
          req_d.addr   = ReqAddr;
          req_d.write  = ReqWrite;
          req_d.strobe = ReqStrobe;
          req_d.wdata  = ReqWData;
          cnt_d        = 4'(WAIT_STATES);
          state_d      = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign word_idx = req_q.addr[ADDR_WIDTH+1:2];
  assign rword    = mem_q[word_idx];
  assign addr_hi  = req_q.addr >> (ADDR_WIDTH + 2);

  dmem_lane_align u_lane_align (
    .addr_lo   (req_q.addr[1:0]),
    .strobe    (req_q.strobe),
    .write     (req_q.write),
    .wdata     (req_q.wdata),
    .rword     (rword),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext),
    .align_err (align_err)
  );

  always_comb begin
    acc_err  = align_err | (|addr_hi);
    ReqReady = (state_q == IDLE);
    RspValid = (state_q == RESP);
    RspError = RspValid & acc_err;
    RspRData = (RspValid && !acc_err && !req_q.write) ? rdata_ext : '0;
    mem_we   = RspValid & req_q.write & ~acc_err;
  end

  // Store commits on the edge that ends RESP; a reset during WAIT drops
  // the FSM to IDLE so the write enable never rises.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_q[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_STATES 1, 0, 3
// sharing request fields, each with its own ReqValid.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [2:0]  vld = '0;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [2:0]  req_strobe = 3'b010;
  logic [31:0] req_wdata = '0;
  logic [2:0]  rdy, rv, er;
  logic [31:0] rd [3];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (
    .CLK(CLK), .RST(RST), .ReqValid(vld[0]), .ReqReady(rdy[0]),
    .ReqAddr(req_addr), .ReqWrite(req_write), .ReqStrobe(req_strobe),
    .ReqWData(req_wdata), .RspValid(rv[0]), .RspRData(rd[0]), .RspError(er[0]));

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
    .CLK(CLK), .RST(RST), .ReqValid(vld[1]), .ReqReady(rdy[1]),
    .ReqAddr(req_addr), .ReqWrite(req_write), .ReqStrobe(req_strobe),
    .ReqWData(req_wdata), .RspValid(rv[1]), .RspRData(rd[1]), .RspError(er[1]));

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
    .CLK(CLK), .RST(RST), .ReqValid(vld[2]), .ReqReady(rdy[2]),
    .ReqAddr(req_addr), .ReqWrite(req_write), .ReqStrobe(req_strobe),
    .ReqWData(req_wdata), .RspValid(rv[2]), .RspRData(rd[2]), .RspError(er[2]));

  // One request on instance s; lat counts negedges after the accept edge
  // before RspValid is seen (equals WAIT_STATES). Returns after RESP ends.
  task automatic do_req(input int s, input logic w, input logic [2:0] st,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output logic e, output int lat);
    @(negedge CLK);
    req_addr = a; req_write = w; req_strobe = st; req_wdata = d;
    vld[s] = 1'b1;
    @(negedge CLK);
    vld[s] = 1'b0;
    lat = 0;
    while (!rv[s] && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    rdata = rd[s];
    e = er[s];
    if (lat >= 40) begin
      total_cnt++;
      $display("FAIL timeout inst=%0d addr=%h: no RspValid within 40 cycles", s, a);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({rdy[i], rv[i], er[i], rd[i]} !== {1'b1, 1'b0, 1'b0, 32'h0})
        $display("FAIL reset inst=%0d rdy/rv/err/rdata got %b%b%b %h want 100 00000000",
                 i, rdy[i], rv[i], er[i], rd[i]);
      else pass_cnt++;
    end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_store_timing();
    logic [31:0] r; logic e; int lat;
    req_addr = 32'h10; req_write = 1'b1; req_strobe = 3'b010; req_wdata = 32'hDEADBEEF;
    vld[0] = 1'b1;
    @(negedge CLK);
    vld[0] = 1'b0;
    total_cnt++;
    if ({rdy[0], rv[0]} !== 2'b00) $display("FAIL sw_cyc1 rdy/rv got %b%b want 00", rdy[0], rv[0]);
    else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if ({rdy[0], rv[0], er[0], rd[0]} !== {3'b010, 32'h0})
      $display("FAIL sw_cyc2 rdy/rv/err/rdata got %b%b%b %h want 010 00000000", rdy[0], rv[0], er[0], rd[0]);
    else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if ({rdy[0], rv[0]} !== 2'b10) $display("FAIL sw_cyc3 rdy/rv got %b%b want 10", rdy[0], rv[0]);
    else pass_cnt++;
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, r, e, lat);
    total_cnt++;
    if ({r, e, lat} !== {32'hDEADBEEF, 1'b0, 32'd1})
      $display("FAIL lw_10 rdata/err/lat got %h %b %0d want deadbeef 0 1", r, e, lat);
    else pass_cnt++;
  endtask

  task automatic test_byte();
    logic [31:0] r; logic e; int lat;
    do_req(0, 1'b1, 3'b000, 32'h11, 32'h000000A5, r, e, lat);
    total_cnt++;
    if ({r, e} !== {32'h0, 1'b0}) $display("FAIL sb_11 rdata/err got %h %b want 00000000 0", r, e);
    else pass_cnt++;
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, r, e, lat);
    total_cnt++;
    if (r !== 32'hDEADA5EF) $display("FAIL lw_after_sb got %h want deada5ef", r);
    else pass_cnt++;
    do_req(0, 1'b0, 3'b000, 32'h11, 32'h0, r, e, lat);
    total_cnt++;
    if (r !== 32'hFFFFFFA5) $display("FAIL lb_11 got %h want ffffffa5", r);
    else pass_cnt++;
    do_req(0, 1'b0, 3'b100, 32'h11, 32'h0, r, e, lat);
    total_cnt++;
    if (r !== 32'h000000A5) $display("FAIL lbu_11 got %h want 000000a5", r);
    else pass_cnt++;
  endtask

  task automatic test_half();
    logic [31:0] r; logic e; int lat;
    do_req(0, 1'b1, 3'b001, 32'h12, 32'h00008001, r, e, lat);
    total_cnt++;
    if (e !== 1'b0) $display("FAIL sh_12 err got %b want 0", e);
    else pass_cnt++;
    do_req(0, 1'b0, 3'b001, 32'h12, 32'h0, r, e, lat);
    total_cnt++;
    if (r !== 32'hFFFF8001) $display("FAIL lh_12 got %h want ffff8001", r);
    else pass_cnt++;
    do_req(0, 1'b0, 3'b101, 32'h12, 32'h0, r, e, lat);
    total_cnt++;
    if (r !== 32'h00008001) $display("FAIL lhu_12 got %h want 00008001", r);
    else pass_cnt++;
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, r, e, lat);
    total_cnt++;
    if (r !== 32'h8001A5EF) $display("FAIL lw_after_sh got %h want 8001a5ef", r);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e; int lat;
    logic        w_t  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  st_t [6] = '{3'b010, 3'b001, 3'b000, 3'b111, 3'b100, 3'b010};
    logic [31:0] a_t  [6] = '{32'h12, 32'h13, 32'h1000, 32'h10, 32'h10, 32'h1010};
    for (int i = 0; i < 6; i++) begin
      do_req(0, w_t[i], st_t[i], a_t[i], 32'h55AA55AA, r, e, lat);
      total_cnt++;
      if ({r, e} !== {32'h0, 1'b1})
        $display("FAIL err_case%0d addr=%h rdata/err got %h %b want 00000000 1", i, a_t[i], r, e);
      else pass_cnt++;
    end
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, r, e, lat);
    total_cnt++;
    if ({r, e} !== {32'h8001A5EF, 1'b0})
      $display("FAIL lw_after_errors rdata/err got %h %b want 8001a5ef 0", r, e);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic e; int lat;
    do_req(1, 1'b1, 3'b010, 32'h0, 32'h11223344, r, e, lat);
    total_cnt++;
    if ({e, lat} !== {1'b0, 32'd0}) $display("FAIL ws0_sw err/lat got %b %0d want 0 0", e, lat);
    else pass_cnt++;
    req_addr = 32'h0; req_write = 1'b0; req_strobe = 3'b010;
    vld[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      total_cnt++;
      if ({rv[1], rdy[1], rd[1]} !== ((i % 2 == 0) ? {2'b10, 32'h11223344} : {2'b01, 32'h0}))
        $display("FAIL b2b_cyc%0d rv/rdy/rdata got %b%b %h want %s", i, rv[1], rdy[1], rd[1],
                 (i % 2 == 0) ? "10 11223344" : "01 00000000");
      else pass_cnt++;
    end
    vld[1] = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic e; int lat; int seen;
    do_req(2, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, r, e, lat);
    total_cnt++;
    if ({e, lat} !== {1'b0, 32'd3}) $display("FAIL ws3_sw err/lat got %b %0d want 0 3", e, lat);
    else pass_cnt++;
    @(negedge CLK);
    req_addr = 32'h20; req_write = 1'b1; req_strobe = 3'b010; req_wdata = 32'h12345678;
    vld[2] = 1'b1;
    @(negedge CLK);
    vld[2] = 1'b0;
    @(negedge CLK);
    total_cnt++;
    if ({rdy[2], rv[2]} !== 2'b00) $display("FAIL ws3_in_wait rdy/rv got %b%b want 00", rdy[2], rv[2]);
    else pass_cnt++;
    RST = 1'b0;
    #1;
    total_cnt++;
    if ({rdy[2], rv[2]} !== 2'b10) $display("FAIL rst_mid rdy/rv got %b%b want 10", rdy[2], rv[2]);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (rv[2]) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL rst_no_rsp responses got %0d want 0", seen);
    else pass_cnt++;
    do_req(2, 1'b0, 3'b010, 32'h20, 32'h0, r, e, lat);
    total_cnt++;
    if ({r, e, lat} !== {32'hCAFEF00D, 1'b0, 32'd3})
      $display("FAIL lw_20_after_rst rdata/err/lat got %h %b %0d want cafef00d 0 3", r, e, lat);
    else pass_cnt++;
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, r, e, lat);
    total_cnt++;
    if (r !== 32'h8001A5EF) $display("FAIL ws1_mem_kept got %h want 8001a5ef", r);
    else pass_cnt++;
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_store_timing();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
